// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter
//   N-point radix-2 decimation-in-time FFT/IFFT built around one time-shared
//   butterfly and an N-entry register buffer. Samples are loaded in
//   bit-reversed order and transformed in place. Bins then stream out in
//   natural order. Every stage halves its results, so the output is DFT/N.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   data_valid/in_ready  input handshake (in_ready high only while loading)
//   data_re, data_im     signed input sample components (DATA_W)
//   inverse              frame direction, sampled with sample 0 (1 = IFFT)
//   fft_valid/fft_ready  output handshake
//   fft_re, fft_im       signed bin components (DATA_W+2)
//   fft_index            bin number, natural order
//   fft_last             marks bin N-1
//   busy                 high while computing or unloading
module fft_radix2_iter #(
    parameter int N      = 8,
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] data_re,
    input  logic signed [DATA_W-1:0] data_im,
    input  logic                     inverse,
    output logic                     fft_valid,
    input  logic                     fft_ready,
    output logic signed [DATA_W+1:0] fft_re,
    output logic signed [DATA_W+1:0] fft_im,
    output logic [$clog2(N)-1:0]     fft_index,
    output logic                     fft_last,
    output logic                     busy
);
    localparam int S  = $clog2(N);
    localparam int OW = DATA_W + 2;
    localparam int PW = OW + TW_W + 1;
    localparam real PI = 3.14159265358979323846;
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (TW_W - 2);

    generate
        if (N != 8 && N != 16 && N != 32) begin : g_bad_n
            $error("fft_radix2_iter: N must be 8, 16 or 32");
        end
    endgenerate

    // Quantise to Q1.(TW_W-1), rounding to nearest; +1.0 saturates.
    function automatic logic signed [TW_W-1:0] to_q(input real v);
        real s;
        int  r;
        int  qmax;
        qmax = (1 << (TW_W - 1)) - 1;
        s = v * (2.0 ** (TW_W - 1));
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(0.5 - s);
        if (r > qmax) r = qmax;
        return TW_W'(r);
    endfunction

    // Quarter... half-circle table of a 32-point transform; smaller N stride through it.
    function automatic logic [16*TW_W-1:0] build_rom(input bit is_sin);
        logic [16*TW_W-1:0] rom;
        rom = '0;
        for (int k = 0; k < 16; k++) begin
            rom[k*TW_W +: TW_W] = is_sin ? to_q($sin(2.0 * PI * k / 32.0))
                                         : to_q($cos(2.0 * PI * k / 32.0));
        end
        return rom;
    endfunction

    localparam logic [16*TW_W-1:0] COS_ROM = build_rom(1'b0);
    localparam logic [16*TW_W-1:0] SIN_ROM = build_rom(1'b1);

    // Round-to-nearest product of a sample component and a twiddle component.
    function automatic logic signed [PW-1:0] mul_rnd(input logic signed [OW-1:0] d,
                                                     input logic signed [TW_W-1:0] c);
        logic signed [PW-1:0] prod;
        prod = PW'(d) * PW'(c);
        return (prod + HALF) >>> (TW_W - 1);
    endfunction

    // Per-stage scaling by 1/2 (floor); the halved value always fits OW bits.
    function automatic logic signed [OW-1:0] half_floor(input logic signed [PW-1:0] v);
        return OW'(v >>> 1);
    endfunction

    function automatic logic [S-1:0] bitrev(input logic [S-1:0] v);
        logic [S-1:0] r;
        for (int i = 0; i < S; i++) r[i] = v[S-1-i];
        return r;
    endfunction

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t               state;
    logic [S-1:0]         load_cnt;
    logic [S-2:0]         bfly_cnt;
    logic [2:0]           stage_cnt;
    logic                 inv_q;
    logic signed [OW-1:0] mem_re [N];
    logic signed [OW-1:0] mem_im [N];

    logic [S-1:0]           j_ext, hmask, p_idx, g_idx, a_addr, b_addr, nxt_idx;
    logic [3:0]             rom_idx;
    logic signed [TW_W-1:0] wr, ws, wi;
    logic signed [OW-1:0]   xr, xi, yr, yi, a_re, a_im, b_re, b_im;
    logic signed [PW-1:0]   tr, ti;

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);

    always_comb begin
        j_ext  = {1'b0, bfly_cnt};
        hmask  = S'(1) << stage_cnt;
        p_idx  = j_ext & (hmask - S'(1));
        g_idx  = j_ext >> stage_cnt;
        a_addr = (g_idx << (stage_cnt + 3'd1)) | p_idx;
        b_addr = a_addr | hmask;
        // k*(32/N) with k = p*N/(2h) reduces to p*16/h in the 32-point table.
        rom_idx = 4'(p_idx) << (3'd4 - stage_cnt);
        wr = COS_ROM[int'(rom_idx)*TW_W +: TW_W];
        ws = SIN_ROM[int'(rom_idx)*TW_W +: TW_W];
        wi = inv_q ? ws : -ws;
        xr = mem_re[a_addr];
        xi = mem_im[a_addr];
        yr = mem_re[b_addr];
        yi = mem_im[b_addr];
        if (p_idx == '0) begin
            tr = PW'(yr);
            ti = PW'(yi);
        end else begin
            tr = mul_rnd(yr, wr) - mul_rnd(yi, wi);
            ti = mul_rnd(yr, wi) + mul_rnd(yi, wr);
        end
        a_re = half_floor(PW'(xr) + tr);
        a_im = half_floor(PW'(xi) + ti);
        b_re = half_floor(PW'(xr) - tr);
        b_im = half_floor(PW'(xi) - ti);
        nxt_idx = fft_index + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            load_cnt  <= '0;
            bfly_cnt  <= '0;
            stage_cnt <= '0;
            inv_q     <= 1'b0;
            fft_valid <= 1'b0;
            fft_re    <= '0;
            fft_im    <= '0;
            fft_index <= '0;
            fft_last  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (data_valid) begin
                        mem_re[bitrev(load_cnt)] <= OW'(data_re);
                        mem_im[bitrev(load_cnt)] <= OW'(data_im);
                        if (load_cnt == '0) inv_q <= inverse;
                        if (load_cnt == S'(N - 1)) begin
                            load_cnt <= '0;
                            state    <= COMPUTE;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    mem_re[a_addr] <= a_re;
                    mem_im[a_addr] <= a_im;
                    mem_re[b_addr] <= b_re;
                    mem_im[b_addr] <= b_im;
                    if (bfly_cnt == '1) begin
                        bfly_cnt <= '0;
                        if (stage_cnt == 3'(S - 1)) begin
                            stage_cnt <= '0;
                            state     <= UNLOAD;
                            fft_valid <= 1'b1;
                            // The final butterfly writes N/2-1 and N-1, never bin 0,
                            // so the pre-write buffer value is already final.
                            fft_re    <= mem_re[0];
                            fft_im    <= mem_im[0];
                            fft_index <= '0;
                            fft_last  <= 1'b0;
                        end else begin
                            stage_cnt <= stage_cnt + 3'd1;
                        end
                    end else begin
                        bfly_cnt <= bfly_cnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (fft_ready) begin
                        if (fft_last) begin
                            state     <= LOAD;
                            fft_valid <= 1'b0;
                            fft_last  <= 1'b0;
                            fft_index <= '0;
                            fft_re    <= '0;
                            fft_im    <= '0;
                        end else begin
                            fft_index <= nxt_idx;
                            fft_re    <= mem_re[nxt_idx];
                            fft_im    <= mem_im[nxt_idx];
                            fft_last  <= (nxt_idx == S'(N - 1));
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_radix2_iter.sv
// tb_fft_radix2_iter
//   Randomised frames against an array-based DFT/N reference with rounded
//   twiddles, plus literal expectations for impulse, DC and inverse frames.
module tb_fft_radix2_iter;
    localparam int N = 8, DATA_W = 16, TW_W = 16, S = 3, OW = DATA_W + 2;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0, rst = 1'b1;
    logic data_valid = 1'b0, inverse = 1'b0, fft_ready = 1'b1;
    logic signed [DATA_W-1:0] data_re = '0, data_im = '0;
    logic in_ready, fft_valid, fft_last, busy;
    logic signed [OW-1:0] fft_re, fft_im;
    logic [S-1:0] fft_index;

    fft_radix2_iter #(.N(N), .DATA_W(DATA_W), .TW_W(TW_W)) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .in_ready(in_ready),
        .data_re(data_re), .data_im(data_im), .inverse(inverse),
        .fft_valid(fft_valid), .fft_ready(fft_ready), .fft_re(fft_re),
        .fft_im(fft_im), .fft_index(fft_index), .fft_last(fft_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int in_re [N], in_im [N];
    longint m_re [N], m_im [N];
    longint exp_re [$], exp_im [$];
    int exp_idx [$];
    bit rdy_mode = 1'b0, last_flag = 1'b0;
    bit stall_prev = 1'b0, lat_armed = 1'b0;
    longint p_re, p_im;
    int p_idx, p_last, cyc = 0, t_acc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint twq(input real v);
        real s;
        longint r;
        s = v * (2.0 ** (TW_W - 1));
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(0.5 - s);
        if (r > (2 ** (TW_W - 1)) - 1) r = (2 ** (TW_W - 1)) - 1;
        return r;
    endfunction

    function automatic longint rnd(input longint p);
        return (p + (64'sd1 <<< (TW_W - 2))) >>> (TW_W - 1);
    endfunction

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < S; i++) if (v[i]) r |= 1 << (S - 1 - i);
        return r;
    endfunction

    // Reference: iterative DIT on plain arrays, rounded twiddle products,
    // each stage halved with floor.
    task automatic model_run(input bit inv);
        longint br [N], bi [N];
        longint tr, ti, wr, wi, ws, xr, xi;
        int h, a, b, k;
        for (int n = 0; n < N; n++) begin
            br[brev(n)] = in_re[n];
            bi[brev(n)] = in_im[n];
        end
        for (int s = 0; s < S; s++) begin
            h = 1 << s;
            for (int j = 0; j < N / 2; j++) begin
                a = (j / h) * 2 * h + (j % h);
                b = a + h;
                k = (j % h) * (N / (2 * h));
                if (k == 0) begin
                    tr = br[b];
                    ti = bi[b];
                end else begin
                    wr = twq($cos(2.0 * PI * k / N));
                    ws = twq($sin(2.0 * PI * k / N));
                    wi = inv ? ws : -ws;
                    tr = rnd(br[b] * wr) - rnd(bi[b] * wi);
                    ti = rnd(br[b] * wi) + rnd(bi[b] * wr);
                end
                xr = br[a];
                xi = bi[a];
                br[a] = (xr + tr) >>> 1;
                bi[a] = (xi + ti) >>> 1;
                br[b] = (xr - tr) >>> 1;
                bi[b] = (xi - ti) >>> 1;
            end
        end
        for (int n = 0; n < N; n++) begin
            m_re[n] = br[n];
            m_im[n] = bi[n];
        end
    endtask

    task automatic send_frame(input bit inv, input bit expect_out);
        bit acc;
        int w;
        model_run(inv);
        if (expect_out) begin
            for (int n = 0; n < N; n++) begin
                exp_re.push_back(m_re[n]);
                exp_im.push_back(m_im[n]);
                exp_idx.push_back(n);
            end
        end
        for (int n = 0; n < N; n++) begin
            @(posedge clk); #1;
            data_valid = 1'b1;
            data_re    = DATA_W'(in_re[n]);
            data_im    = DATA_W'(in_im[n]);
            inverse    = (n == 0) ? inv : 1'($urandom);
            last_flag  = (n == N - 1);
            w = 0;
            acc = 1'b0;
            while (!acc && w < 500) begin
                @(negedge clk);
                acc = in_ready;
                if (!acc) begin
                    @(posedge clk); #1;
                end
                w++;
            end
            if (!acc) chk("load_timeout", 0, 1);
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
        last_flag  = 1'b0;
        data_re    = DATA_W'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_re.size() > 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (exp_re.size() > 0) chk("drain_timeout", exp_re.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fft_valid"}, fft_valid, 0);
        chk({tag, "_fft_re"}, fft_re, 0);
        chk({tag, "_fft_im"}, fft_im, 0);
        chk({tag, "_fft_index"}, fft_index, 0);
        chk({tag, "_fft_last"}, fft_last, 0);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        check_reset_vals(tag);
        exp_re.delete();
        exp_im.delete();
        exp_idx.delete();
        stall_prev = 1'b0;
        lat_armed  = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    task automatic rand_frame();
        logic signed [DATA_W-1:0] v;
        for (int n = 0; n < N; n++) begin
            v = DATA_W'($urandom);
            in_re[n] = int'(v);
            v = DATA_W'($urandom);
            in_im[n] = int'(v);
        end
    endtask

    task automatic set_frame(input int r0, input int rest);
        for (int n = 0; n < N; n++) begin
            in_re[n] = (n == 0) ? r0 : rest;
            in_im[n] = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            fft_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Output compare: order, values, index, last, stall stability, latency.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
            lat_armed  = 1'b0;
        end else begin
            if (data_valid && in_ready && last_flag) begin
                t_acc = cyc;
                lat_armed = 1'b1;
            end
            if (lat_armed && fft_valid) begin
                chk("latency", cyc - t_acc, 1 + S * N / 2);
                lat_armed = 1'b0;
            end
            if (stall_prev) begin
                checks++;
                if (!(fft_valid && fft_re == p_re && fft_im == p_im &&
                      int'(fft_index) == p_idx && int'(fft_last) == p_last)) begin
                    errors++;
                    $display("FAIL stall_hold actual=%0d/%0d/%0d/%0d/%0d required=1/%0d/%0d/%0d/%0d",
                             fft_valid, fft_re, fft_im, fft_index, fft_last, p_re, p_im, p_idx, p_last);
                end
            end
            if (fft_valid && fft_ready) begin
                if (exp_re.size() == 0) begin
                    chk("unexpected_bin", fft_index, -1);
                end else begin
                    checks++;
                    if (fft_re != exp_re[0] || fft_im != exp_im[0] ||
                        int'(fft_index) != exp_idx[0] || int'(fft_last) != int'(exp_idx[0] == N - 1)) begin
                        errors++;
                        $display("FAIL bin actual re=%0d im=%0d k=%0d last=%0d required re=%0d im=%0d k=%0d last=%0d",
                                 fft_re, fft_im, fft_index, fft_last, exp_re[0], exp_im[0],
                                 exp_idx[0], exp_idx[0] == N - 1);
                    end
                    void'(exp_re.pop_front());
                    void'(exp_im.pop_front());
                    void'(exp_idx.pop_front());
                end
            end
            stall_prev = fft_valid && !fft_ready;
            p_re = fft_re;
            p_im = fft_im;
            p_idx = int'(fft_index);
            p_last = int'(fft_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Impulse 1000 -> every bin 125 + j0.
        set_frame(1000, 0);
        model_run(1'b0);
        for (int k = 0; k < N; k++) begin
            chk("model_impulse_re", m_re[k], 125);
            chk("model_impulse_im", m_im[k], 0);
        end
        send_frame(1'b0, 1'b1);
        drain();

        // DC 800 -> bin0 800, everything else exactly zero.
        set_frame(800, 800);
        model_run(1'b0);
        for (int k = 0; k < N; k++) begin
            chk("model_dc_re", m_re[k], (k == 0) ? 800 : 0);
            chk("model_dc_im", m_im[k], 0);
        end
        send_frame(1'b0, 1'b1);
        drain();

        // Inverse of the DC spectrum scaled by 8 -> every sample 800.
        set_frame(6400, 0);
        model_run(1'b1);
        for (int k = 0; k < N; k++) chk("model_inv_re", m_re[k], 800);
        send_frame(1'b1, 1'b1);
        drain();

        // Random frames, both directions, back-to-back, with output stalls.
        rdy_mode = 1'b1;
        for (int f = 0; f < 20; f++) begin
            rand_frame();
            send_frame(1'($urandom), 1'b1);
        end
        drain();

        // Reset during COMPUTE, then a clean frame.
        rand_frame();
        send_frame(1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset_pulse("rst_compute");
        rand_frame();
        send_frame(1'b0, 1'b1);
        drain();

        // Reset during UNLOAD after a few bins, then a clean frame.
        rand_frame();
        send_frame(1'b1, 1'b1);
        begin
            int w = 0;
            while (exp_re.size() > N - 3 && w < 1000) begin
                @(negedge clk);
                w++;
            end
        end
        #1;
        chk("in_unload_busy", busy, 1);
        reset_pulse("rst_unload");
        rand_frame();
        send_frame(1'b1, 1'b1);
        drain();

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
